// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_faob.sv
// One-bit full adder cell, the shared datapath element of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: i_a, i_b, i_cin operand/carry bits; o_q sum bit; o_cout carry out.
module serial_adder_ctrl_faob (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_q,
  output logic o_cout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_q    = w_axb ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell stepped over N cycles, LSB first.
// Latency: start accepted at edge t -> DONE_out high after edge t+N; one add per N+1 cycles.
// Backpressure: START_in accepted only in IDLE/DONE; ignored (not queued) while BUSY_out.
// Ports: CLK_in clock; RST_in async active-high reset; START_in request; A_in/B_in/C_in
//        operands captured on accept; BUSY_out in SHIFT; DONE_out one-cycle pulse;
//        Q_out/C_out sum and carry, updated on SHIFT->DONE and held until the next result.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK_in,
  input  logic         RST_in,
  input  logic         START_in,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic         C_in,
  output logic         BUSY_out,
  output logic         DONE_out,
  output logic [N-1:0] Q_out,
  output logic         C_out
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  state_t        r_state;
  logic [N-1:0]  r_a_sh;
  logic [N-1:0]  r_b_sh;
  logic [N-1:0]  r_q_sh;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_q;
  logic          r_c;

  logic          w_fa_q;
  logic          w_fa_cout;
  logic [N:0]    w_q_cat;
  logic [N-1:0]  w_q_next;

  serial_adder_ctrl_faob u_faob (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_q    (w_fa_q),
    .o_cout (w_fa_cout)
  );

  // New sum bit enters at the MSB and the partial sum shifts right; after N
  // steps the LSB-first bits sit in their natural positions. Shifting the
  // concatenation keeps this valid for N=1 as well.
  assign w_q_cat  = {w_fa_q, r_q_sh};
  assign w_q_next = N'(w_q_cat >> 1);

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_q_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE, giving back-to-back adds.
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (START_in) begin
            r_a_sh  <= A_in;
            r_b_sh  <= B_in;
            r_carry <= C_in;
            r_q_sh  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_q_sh  <= w_q_next;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            // Result registers move only here, so they hold through IDLE
            // and through the next operation's SHIFT phase.
            r_q     <= w_q_next;
            r_c     <= w_fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY_out = r_busy;
  assign DONE_out = r_done;
  assign Q_out    = r_q;
  assign C_out    = r_c;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with an N=8 and an N=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c8;
  logic       busy8;
  logic       done8;
  logic [7:0] q8;
  logic       co8;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c1;
  logic       busy1;
  logic       done1;
  logic [0:0] q1;
  logic       co1;

  int checks   = 0;
  int failures = 0;

  // Expected {C_out,Q_out} for each N=8 DONE pulse, in order.
  logic [8:0] exp_q[$];

  serial_adder_ctrl #(.N(8)) dut8 (
    .CLK_in(clk), .RST_in(rst), .START_in(start8), .A_in(a8), .B_in(b8), .C_in(c8),
    .BUSY_out(busy8), .DONE_out(done8), .Q_out(q8), .C_out(co8)
  );

  serial_adder_ctrl #(.N(1)) dut1 (
    .CLK_in(clk), .RST_in(rst), .START_in(start1), .A_in(a1), .B_in(b1), .C_in(c1),
    .BUSY_out(busy1), .DONE_out(done1), .Q_out(q1), .C_out(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every-cycle checks: mutual exclusion and reference model at each DONE.
  always @(negedge clk) begin
    checks++;
    if (busy8 === 1'b1 && done8 === 1'b1) begin
      failures++;
      $display("FAIL mutex8: busy=%b done=%b, required not both high", busy8, done8);
    end
    checks++;
    if (busy1 === 1'b1 && done1 === 1'b1) begin
      failures++;
      $display("FAIL mutex1: busy=%b done=%b, required not both high", busy1, done1);
    end
    if (done8 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL model8: unexpected DONE with {c,q}=%h", {co8, q8});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({co8, q8} !== e) begin
          failures++;
          $display("FAIL model8: {c,q}=%h required %h", {co8, q8}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one N=8 add and wait (bounded) until DONE is seen after #1 of an edge.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output bit got);
    got = 1'b0;
    tick();
    start8 = 1'b1; a8 = a; b8 = b; c8 = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    tick();
    start8 = 1'b0; a8 = 8'hXX; b8 = 8'hXX; c8 = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, q8, co8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outs8: got %b required 0", {busy8, done8, q8, co8});
    end
    checks++;
    if ({busy1, done1, q1, co1} !== 4'd0) begin
      failures++;
      $display("FAIL reset_outs1: got %b required 0", {busy1, done1, q1, co1});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy8, done8, q8, co8} !== 11'd0) begin
        failures++;
        $display("FAIL idle_hold cycle %0d: got %b required 0", i, {busy8, done8, q8, co8});
      end
    end
  endtask

  task automatic test_basic();
    tick();
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h05; c8 = 1'b0;
    exp_q.push_back(9'h041);
    tick();  // accept edge
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b required busy=1 done=0", i, busy8, done8);
      end
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_time: busy=%b done=%b required busy=0 done=1", busy8, done8);
    end
    checks++;
    if (q8 !== 8'h41 || co8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: q=%h c=%b required q=41 c=0", q8, co8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || q8 !== 8'h41) begin
      failures++;
      $display("FAIL basic_hold: done=%b q=%h required done=0 q=41", done8, q8);
    end
  endtask

  task automatic test_carry_wrap();
    bit got;
    do_op8(8'hFF, 8'h00, 1'b1, got);
    checks++;
    if (!got || q8 !== 8'h00 || co8 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ff_00_1: done_seen=%b q=%h c=%b required q=00 c=1", got, q8, co8);
    end
    do_op8(8'hFF, 8'hFF, 1'b1, got);
    checks++;
    if (!got || q8 !== 8'hFF || co8 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ff_ff_1: done_seen=%b q=%h c=%b required q=ff c=1", got, q8, co8);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    exp_q.push_back(9'h046);
    tick();  // accept edge
    // START stays high; operands scrambled during SHIFT must not matter.
    for (int i = 0; i < 8; i++) begin
      a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || q8 !== 8'h46 || co8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: done=%b q=%h c=%b required done=1 q=46 c=0", done8, q8, co8);
    end
    a8 = 8'h70; b8 = 8'h0F; c8 = 1'b1;
    exp_q.push_back(9'h080);
    tick();  // second accept, from DONE
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap cycle %0d: busy=%b done=%b required busy=1 done=0", i, busy8, done8);
      end
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || q8 !== 8'h80 || co8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: done=%b q=%h c=%b required done=1 q=80 c=0", done8, q8, co8);
    end
  endtask

  task automatic test_reset_midop();
    bit got;
    tick();
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; c8 = 1'b0;
    tick();  // accept edge, SHIFT cycle 1
    start8 = 1'b0;
    tick();
    tick();
    tick();  // SHIFT cycle 4
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, q8, co8} !== 11'd0) begin
      failures++;
      $display("FAIL midop_reset: got %b required 0", {busy8, done8, q8, co8});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL midop_no_done cycle %0d: busy=%b done=%b required 0 0", i, busy8, done8);
      end
    end
    do_op8(8'h10, 8'h20, 1'b0, got);
    checks++;
    if (!got || q8 !== 8'h30 || co8 !== 1'b0) begin
      failures++;
      $display("FAIL midop_after: done_seen=%b q=%h c=%b required q=30 c=0", got, q8, co8);
    end
  endtask

  task automatic test_n1();
    tick();
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    tick();  // accept edge
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL n1_busy: busy=%b done=%b required busy=1 done=0", busy1, done1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || q1 !== 1'b1 || co1 !== 1'b1) begin
      failures++;
      $display("FAIL n1_111: done=%b q=%b c=%b required 1 1 1", done1, q1, co1);
    end
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    start1 = 1'b1;
    tick();  // accept from DONE
    start1 = 1'b0;
    tick();
    checks++;
    if (done1 !== 1'b1 || q1 !== 1'b1 || co1 !== 1'b0) begin
      failures++;
      $display("FAIL n1_010: done=%b q=%b c=%b required 1 1 0", done1, q1, co1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0 || q1 !== 1'b1) begin
      failures++;
      $display("FAIL n1_hold: done=%b q=%b required done=0 q=1", done1, q1);
    end
  endtask

  initial begin
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    test_reset();
    test_basic();
    test_carry_wrap();
    test_back_to_back();
    test_reset_midop();
    test_n1();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_done: %0d results never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
